// File: rtl/mem_access_seq_pkg.sv
// Shared types and default widths for the load/store sequencer.
package mem_access_seq_pkg;

  localparam int unsigned DefW = 8;  // memory data width
  localparam int unsigned DefA = 8;  // memory address width

  typedef enum logic [1:0] {
    StIdle,
    StLo,
    StHi,
    StResp
  } mas_state_t;

  // One core request at the default widths.
  typedef struct packed {
    logic                  write;
    logic                  wide;
    logic [DefA-1:0]       addr;
    logic [2*DefW-1:0]     data;
  } mas_req_t;

endpackage

// File: rtl/mem_access_seq.sv
// Load/store sequencer: splits 2W-bit accesses into two little-endian byte
// accesses on a single-port byte memory and returns a one-cycle response.
module mem_access_seq
  import mem_access_seq_pkg::*;
#(
  parameter int unsigned W = DefW,
  parameter int unsigned A = DefA
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           req_valid_i,
  output logic           req_ready_o,
  input  logic           req_write_i,
  input  logic           req_wide_i,
  input  logic [A-1:0]   req_addr_i,
  input  logic [2*W-1:0] req_data_i,
  output logic           resp_valid_o,
  output logic [2*W-1:0] resp_data_o,
  output logic [A-1:0]   mem_addr_o,
  output logic           mem_write_en_o,
  output logic [W-1:0]   mem_wdata_o,
  input  logic [W-1:0]   mem_rdata_i
);

  mas_state_t     state_q, state_d;
  logic           write_q, write_d;
  logic           wide_q, wide_d;
  logic [A-1:0]   addr_q, addr_d;
  logic [2*W-1:0] data_q, data_d;
  logic [2*W-1:0] result_q, result_d;
  logic [A-1:0]   addr_hi;

  // High byte address wraps at the top of memory; carry is discarded.
  assign addr_hi = addr_q + A'(1);

  // State and latched request; reset aborts any access in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      write_q  <= 1'b0;
      wide_q   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      wide_q   <= wide_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      result_q <= result_d;
    end
  end

  // Next state and outputs decoded purely from registered state.
  always_comb begin
    state_d        = state_q;
    write_d        = write_q;
    wide_d         = wide_q;
    addr_d         = addr_q;
    data_d         = data_q;
    result_d       = result_q;
    req_ready_o    = 1'b0;
    resp_valid_o   = 1'b0;
    resp_data_o    = '0;
    mem_addr_o     = '0;
    mem_write_en_o = 1'b0;
    mem_wdata_o    = '0;

    unique case (state_q)
      StIdle: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          write_d  = req_write_i;
          wide_d   = req_wide_i;
          addr_d   = req_addr_i;
          data_d   = req_data_i;
          // Cleared here so byte loads zero-extend and stores return 0.
          result_d = '0;
          state_d  = StLo;
        end
      end
      StLo: begin
        mem_addr_o = addr_q;
        if (write_q) begin
          mem_write_en_o = 1'b1;
          mem_wdata_o    = data_q[W-1:0];
        end else begin
          result_d[W-1:0] = mem_rdata_i;
        end
        state_d = wide_q ? StHi : StResp;
      end
      StHi: begin
        mem_addr_o = addr_hi;
        if (write_q) begin
          mem_write_en_o = 1'b1;
          mem_wdata_o    = data_q[2*W-1:W];
        end else begin
          result_d[2*W-1:W] = mem_rdata_i;
        end
        state_d = StResp;
      end
      StResp: begin
        resp_valid_o = 1'b1;
        resp_data_o  = result_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule
